// File: rtl/rv32_pkg.sv
// Shared RV32 constants and types for the fetch front end.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] word;
    } fetch_entry_t;

    // Fetch targets are word aligned; low two bits are discarded.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response, redirect and decode handshakes of the fetch unit.
interface instr_fetch_unit_if
    import rv32_pkg::*;
();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; push and pop may coincide at any fill level.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : ptr + AW'(1'b1);
    endfunction

    assign o_empty = (r_count == {CW{1'b0}});
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_push  = i_push & ~i_flush & (~o_full | i_pop);
    assign w_pop   = i_pop & ~i_flush & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage; cleared on reset so the head reads zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            else        r_wr_ptr <= r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            else        r_rd_ptr <= r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Protocol assertions for the fetch unit's buffer and request port.
module instr_fetch_unit_chk #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst_n,
    input logic            i_push,
    input logic            i_pop,
    input logic            i_full,
    input logic            i_req_valid,
    input logic [XLEN-1:0] i_req_addr
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (i_push && i_full) |-> i_pop);

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        i_req_valid |-> (i_req_addr[1:0] == 2'b00));
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, response buffering and redirect squash.
module instr_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              EW      = $bits(fetch_entry_t);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_out_next;
    logic [CW:0]     w_inflight;
    logic            w_empty;
    logic            w_full;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_instr_valid;
    logic [XLEN-1:0] w_redirect_pc;
    logic [EW-1:0]   w_head_bits;
    fetch_entry_t    w_head;
    fetch_entry_t    w_tail;

    // Credit covers both words in flight and words already buffered.
    assign w_inflight    = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req_valid   = (w_inflight < DEPTH_W);
    assign w_req_fire    = w_req_valid & bus.imem_req_ready;
    assign w_out_next    = r_outstanding + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);
    assign w_push        = bus.imem_rsp_valid & ~bus.redirect_valid & (r_discard == {CW{1'b0}});
    assign w_instr_valid = ~w_empty & ~bus.redirect_valid;
    assign w_pop         = w_instr_valid & bus.instr_ready;
    assign w_redirect_pc = pc_align(bus.redirect_pc);
    assign w_tail        = '{pc: r_rpc, word: bus.imem_rsp_data};
    assign w_head        = fetch_entry_t'(w_head_bits);

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fpc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr          = w_head.word;
    assign bus.instr_pc       = w_head.pc;

    // PCs and in-flight bookkeeping; a redirect squashes everything still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_rpc         <= RESET_PC;
            r_outstanding <= {CW{1'b0}};
            r_discard     <= {CW{1'b0}};
        end else if (bus.redirect_valid) begin
            r_fpc         <= w_redirect_pc;
            r_rpc         <= w_redirect_pc;
            r_outstanding <= w_out_next;
            r_discard     <= w_out_next;
        end else begin
            r_outstanding <= w_out_next;
            if (w_req_fire) r_fpc <= r_fpc + PC_STEP;
            else            r_fpc <= r_fpc;
            if (bus.imem_rsp_valid && (r_discard != {CW{1'b0}})) begin
                r_discard <= r_discard - CW'(1'b1);
                r_rpc     <= r_rpc;
            end else if (bus.imem_rsp_valid) begin
                r_discard <= r_discard;
                r_rpc     <= r_rpc + PC_STEP;
            end else begin
                r_discard <= r_discard;
                r_rpc     <= r_rpc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata (w_tail),
        .o_rdata (w_head_bits),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    instr_fetch_unit_chk #(
        .XLEN (XLEN)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_full      (w_full),
        .i_req_valid (w_req_valid),
        .i_req_addr  (r_fpc)
    );
endmodule
